// File: rtl/lane_read_training_ctrl_if.sv
// Lane read-training bus: training request, lane/IOD observations in,
// delay-line controls and training status out.
//
// Handshake: start is a one-cycle request that is accepted only while busy=0
// (idle, done or failed); once accepted busy rises on the next cycle and stays
// high until exactly one of done/error rises, which then holds until the next
// accepted start or a reset. There is no backpressure anywhere on this bus.
interface lane_read_training_ctrl_if;
    logic       start;
    logic [7:0] rx_data;
    logic       eye_monitor_early;
    logic       eye_monitor_late;
    logic       delay_line_out_of_range;
    logic       delay_line_load;
    logic       delay_line_move;
    logic       delay_line_direction;
    logic       eye_monitor_clear_flags;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] tap_val;
    logic [7:0] win_left;
    logic [7:0] win_right;
    logic [3:0] state_dbg;

    // Controller side
    modport master (
        input  start, rx_data, eye_monitor_early, eye_monitor_late,
               delay_line_out_of_range,
        output delay_line_load, delay_line_move, delay_line_direction,
               eye_monitor_clear_flags, busy, done, error,
               tap_val, win_left, win_right, state_dbg
    );

    // Lane / IOD side
    modport slave (
        output start, rx_data, eye_monitor_early, eye_monitor_late,
               delay_line_out_of_range,
        input  delay_line_load, delay_line_move, delay_line_direction,
               eye_monitor_clear_flags, busy, done, error,
               tap_val, win_left, win_right, state_dbg
    );
endinterface

// File: rtl/lane_read_training_ctrl.sv
// Read-training controller for one lane: sweeps the IOD delay line upward,
// finds the contiguous window of taps where the training pattern is received
// cleanly, then walks the delay back down to the window centre.
// Every output is a flop; next-state logic precomputes next-cycle outputs.
module lane_read_training_ctrl #(
    parameter int unsigned TAP_MAX     = 255,
    parameter int unsigned SETTLE_CYC  = 8,
    parameter int unsigned SAMPLE_CYC  = 16,
    parameter logic [7:0]  EXP_PATTERN = 8'h55,
    parameter int unsigned MIN_WINDOW  = 4
) (
    input logic                        fab_clk,
    input logic                        rx_sync_rst,
    lane_read_training_ctrl_if.master  lane
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_SETTLE = 4'd2,
        S_CLEAR  = 4'd3,
        S_SAMPLE = 4'd4,
        S_EVAL   = 4'd5,
        S_STEP   = 4'd6,
        S_CENTER = 4'd7,
        S_DONE   = 4'd8,
        S_FAIL   = 4'd9
    } state_t;

    localparam logic [7:0]  TAP_LAST    = 8'(TAP_MAX);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYC - 1);
    localparam logic [8:0]  MIN_W       = 9'(MIN_WINDOW);

    state_t      state_q, state_n;
    logic [15:0] cnt_q, cnt_n;
    logic [7:0]  tap_q, tap_n;
    logic [7:0]  wl_q, wl_n;
    logic [7:0]  wr_q, wr_n;
    logic [7:0]  target_q, target_n;
    logic        found_left_q, found_left_n;
    logic        pass_q, pass_n;
    logic        load_q, move_q, dir_q, clr_q, busy_q, done_q, error_q;
    logic        load_n, move_n, dir_n, clr_n, busy_n, done_n, error_n;
    logic        sample_bad, at_end, go_center;
    logic [8:0]  width, sum;

    // Registers: state, counters, window bookkeeping and all outputs.
    always_ff @(posedge fab_clk) begin
        if (rx_sync_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tap_q        <= '0;
            wl_q         <= '0;
            wr_q         <= '0;
            target_q     <= '0;
            found_left_q <= 1'b0;
            pass_q       <= 1'b0;
            load_q       <= 1'b0;
            move_q       <= 1'b0;
            dir_q        <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            tap_q        <= tap_n;
            wl_q         <= wl_n;
            wr_q         <= wr_n;
            target_q     <= target_n;
            found_left_q <= found_left_n;
            pass_q       <= pass_n;
            load_q       <= load_n;
            move_q       <= move_n;
            dir_q        <= dir_n;
            clr_q        <= clr_n;
            busy_q       <= busy_n;
            done_q       <= done_n;
            error_q      <= error_n;
        end
    end

    // Next state, window search and next-cycle output values.
    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q + 16'd1;
        tap_n        = tap_q;
        wl_n         = wl_q;
        wr_n         = wr_q;
        target_n     = target_q;
        found_left_n = found_left_q;
        pass_n       = pass_q;
        go_center    = 1'b0;
        width        = '0;
        sum          = '0;
        sample_bad   = (lane.rx_data != EXP_PATTERN) | lane.eye_monitor_early
                       | lane.eye_monitor_late;
        at_end       = (tap_q == TAP_LAST) | lane.delay_line_out_of_range;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (lane.start) begin
                    state_n      = S_LOAD;
                    tap_n        = '0;
                    wl_n         = '0;
                    wr_n         = '0;
                    found_left_n = 1'b0;
                end
            end
            S_LOAD: begin
                tap_n   = '0;
                state_n = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) state_n = S_CLEAR;
            end
            S_CLEAR: begin
                pass_n  = 1'b1;
                state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (sample_bad) pass_n = 1'b0;
                if (cnt_q == SAMPLE_LAST) state_n = S_EVAL;
            end
            S_EVAL: begin
                // First clean tap opens the window.
                if (pass_q && !found_left_q) begin
                    wl_n         = tap_q;
                    found_left_n = 1'b1;
                end
                // First dirty tap after the window closes it; at the top of
                // the delay range a still-clean window closes on this tap.
                if (!pass_q && found_left_q) begin
                    wr_n      = tap_q - 8'd1;
                    go_center = 1'b1;
                end else if (at_end) begin
                    if (pass_q) begin
                        wr_n      = tap_q;
                        go_center = 1'b1;
                    end else begin
                        state_n = S_FAIL;
                    end
                end else begin
                    state_n = S_STEP;
                end
                if (go_center) begin
                    width = {1'b0, wr_n} - {1'b0, wl_n} + 9'd1;
                    sum   = {1'b0, wl_n} + {1'b0, wr_n};
                    if (width < MIN_W) begin
                        state_n = S_FAIL;
                    end else begin
                        state_n  = S_CENTER;
                        target_n = sum[8:1];
                    end
                end
            end
            S_STEP: begin
                tap_n   = tap_q + 8'd1;
                state_n = S_SETTLE;
            end
            S_CENTER: begin
                // The pulse currently on the line has already moved the tap.
                if (move_q) tap_n = tap_q - 8'd1;
                if (lane.delay_line_out_of_range) state_n = S_FAIL;
                else if (tap_n <= target_q)       state_n = S_DONE;
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n != state_q) cnt_n = '0;

        load_n  = (state_n == S_LOAD);
        clr_n   = (state_n == S_CLEAR);
        dir_n   = (state_n == S_STEP);
        move_n  = (state_n == S_STEP) || ((state_n == S_CENTER) && (tap_n > target_n));
        done_n  = (state_n == S_DONE);
        error_n = (state_n == S_FAIL);
        busy_n  = !((state_n == S_IDLE) || (state_n == S_DONE) || (state_n == S_FAIL));
    end

    assign lane.delay_line_load         = load_q;
    assign lane.delay_line_move         = move_q;
    assign lane.delay_line_direction    = dir_q;
    assign lane.eye_monitor_clear_flags = clr_q;
    assign lane.busy                    = busy_q;
    assign lane.done                    = done_q;
    assign lane.error                   = error_q;
    assign lane.tap_val                 = tap_q;
    assign lane.win_left                = wl_q;
    assign lane.win_right               = wr_q;
    assign lane.state_dbg               = state_q;

endmodule

// File: tb/tb_lane_read_training_ctrl.sv
// Bench for lane_read_training_ctrl: a behavioural lane/IOD model feeds the
// controller, directed cases push hand-computed results into exp_q and a
// monitor pops/compares whenever training completes (done or error rises).
module tb_lane_read_training_ctrl;

    localparam logic [7:0] EXP = 8'h55;

    typedef struct packed {
        logic        done;
        logic        error;
        logic        busy;
        logic [7:0]  win_left;
        logic [7:0]  win_right;
        logic [7:0]  tap;
        logic [15:0] inc;
        logic [15:0] dec;
        logic [7:0]  loads;
        logic [7:0]  gap_lc;
        logic [7:0]  gap_cm;
    } rec_t;
    localparam int REC_W = $bits(rec_t);

    logic [REC_W-1:0] exp_q[$];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    lane_read_training_ctrl_if lane();

    lane_read_training_ctrl dut (
        .fab_clk     (clk),
        .rx_sync_rst (rst),
        .lane        (lane.master)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Lane environment configuration
    int cfg_lo = 300;
    int cfg_hi = 0;
    bit cfg_early = 1'b0;
    bit cfg_oor = 1'b0;
    int model_tap = 0;

    // IOD delay-line model follows the controller's load/move pulses.
    always @(posedge clk) begin
        if (lane.delay_line_load)      model_tap <= 0;
        else if (lane.delay_line_move) model_tap <= lane.delay_line_direction ? model_tap + 1 : model_tap - 1;
    end

    // Lane data and IOD flags, all changed away from the active edge.
    always @(negedge clk) begin
        if (model_tap >= cfg_lo && model_tap <= cfg_hi) lane.rx_data = EXP;
        else                                            lane.rx_data = EXP ^ 8'(1 << (model_tap % 8));
        if (rst || lane.eye_monitor_clear_flags)        lane.eye_monitor_early = 1'b0;
        else if (cfg_early && model_tap == 45)          lane.eye_monitor_early = 1'b1;
        lane.eye_monitor_late = 1'b0;
        lane.delay_line_out_of_range = cfg_oor && lane.delay_line_move && !lane.delay_line_direction;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pulse accounting, protocol checks and completion scoreboard.
    int  cyc = 0, t_load = 0, t_clr = 0;
    int  inc_cnt = 0, dec_cnt = 0, load_cnt = 0, gap_lc = 0, gap_cm = 0;
    bit  got_clr = 1'b0, got_cm = 1'b0, fin_prev = 1'b0;
    int  fin_cnt = 0, proto_err = 0;

    always @(posedge clk) begin
        rec_t e;
        bit   fin;
        #1;
        cyc++;
        if (lane.delay_line_move && lane.delay_line_load) proto_err++;
        if (lane.delay_line_direction && !lane.delay_line_move) proto_err++;
        if (rst) load_cnt = 0;
        if (lane.delay_line_load) begin
            inc_cnt = 0; dec_cnt = 0; gap_lc = 0; gap_cm = 0;
            got_clr = 1'b0; got_cm = 1'b0; t_load = cyc;
            load_cnt++;
        end
        if (lane.delay_line_move) begin
            if (lane.delay_line_direction) inc_cnt++;
            else                           dec_cnt++;
            if (got_clr && !got_cm) begin
                gap_cm = cyc - t_clr;
                got_cm = 1'b1;
            end
        end
        if (lane.eye_monitor_clear_flags && !got_clr) begin
            t_clr   = cyc;
            gap_lc  = cyc - t_load;
            got_clr = 1'b1;
        end
        fin = lane.done || lane.error;
        if (fin && !fin_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion: got done=%0d error=%0d expected none", lane.done, lane.error);
            end else begin
                e = rec_t'(exp_q.pop_front());
                chk("done",      int'(lane.done),      int'(e.done));
                chk("error",     int'(lane.error),     int'(e.error));
                chk("busy",      int'(lane.busy),      int'(e.busy));
                chk("win_left",  int'(lane.win_left),  int'(e.win_left));
                chk("win_right", int'(lane.win_right), int'(e.win_right));
                chk("tap_val",   int'(lane.tap_val),   int'(e.tap));
                chk("inc_moves", inc_cnt,              int'(e.inc));
                chk("dec_moves", dec_cnt,              int'(e.dec));
                chk("loads",     load_cnt,             int'(e.loads));
                chk("settle_gap", gap_lc,              int'(e.gap_lc));
                chk("sample_gap", gap_cm,              int'(e.gap_cm));
            end
            load_cnt = 0;
            fin_cnt++;
        end
        fin_prev = fin;
    end

    function automatic rec_t mk(input bit d, input bit er, input int wl, input int wr,
                                input int tap, input int inc, input int dec);
        rec_t r;
        r.done = d; r.error = er; r.busy = 1'b0;
        r.win_left = 8'(wl); r.win_right = 8'(wr); r.tap = 8'(tap);
        r.inc = 16'(inc); r.dec = 16'(dec);
        r.loads = 8'd1; r.gap_lc = 8'd9; r.gap_cm = 8'd18;
        return r;
    endfunction

    // Driver: configure the lane, issue start, wait (bounded) for completion.
    task automatic run_case(input string tag, input int lo, input int hi, input bit early,
                            input bit oor, input bit mid_start, input rec_t e);
        int base;
        int n;
        cfg_lo = lo; cfg_hi = hi; cfg_early = early; cfg_oor = oor;
        @(negedge clk);
        exp_q.push_back(REC_W'(e));
        base = fin_cnt;
        lane.start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_load_pulse"}, int'(lane.delay_line_load), 1);
        chk({tag, "_busy"},       int'(lane.busy), 1);
        @(negedge clk);
        lane.start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_tap_start"},  int'(lane.tap_val), 0);
        if (mid_start) begin
            repeat (100) @(negedge clk);
            lane.start = 1'b1;
            @(negedge clk);
            lane.start = 1'b0;
        end
        n = 0;
        while (fin_cnt == base && n < 12000) begin
            @(posedge clk);
            n++;
        end
        if (fin_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no completion expected done or error within 12000 cycles", tag);
            void'(exp_q.pop_back());
            @(negedge clk); rst = 1'b1;
            @(negedge clk); rst = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_load"},  int'(lane.delay_line_load), 0);
        chk({tag, "_move"},  int'(lane.delay_line_move), 0);
        chk({tag, "_dir"},   int'(lane.delay_line_direction), 0);
        chk({tag, "_clr"},   int'(lane.eye_monitor_clear_flags), 0);
        chk({tag, "_busy"},  int'(lane.busy), 0);
        chk({tag, "_done"},  int'(lane.done), 0);
        chk({tag, "_error"}, int'(lane.error), 0);
        chk({tag, "_tap"},   int'(lane.tap_val), 0);
        chk({tag, "_wl"},    int'(lane.win_left), 0);
        chk({tag, "_wr"},    int'(lane.win_right), 0);
        chk({tag, "_state"}, int'(lane.state_dbg), 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        lane.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("por");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean window 40..60, with an ignored start mid-training.
        run_case("win40_60", 40, 60, 1'b0, 1'b0, 1'b1, mk(1, 0, 40, 60, 50, 61, 11));
        // Never matches: full sweep then failure.
        run_case("never", 300, 0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 0, 255, 255, 0));
        // Window too narrow.
        run_case("narrow", 100, 102, 1'b0, 1'b0, 1'b0, mk(0, 1, 100, 102, 103, 103, 0));
        // Window running into the top tap.
        run_case("top", 250, 255, 1'b0, 1'b0, 1'b0, mk(1, 0, 250, 255, 252, 255, 3));
        // Eye-monitor early flag at tap 45 truncates the window.
        run_case("early45", 40, 60, 1'b1, 1'b0, 1'b0, mk(1, 0, 40, 44, 42, 45, 3));
        // Delay line out of range on the first centring pulse.
        run_case("oor_center", 40, 60, 1'b0, 1'b1, 1'b0, mk(0, 1, 40, 60, 60, 61, 1));

        // Reset mid-training at tap 30, with start asserted in the same cycle.
        cfg_lo = 40; cfg_hi = 60; cfg_early = 1'b0; cfg_oor = 1'b0;
        @(negedge clk);
        lane.start = 1'b1;
        @(negedge clk);
        lane.start = 1'b0;
        n = 0;
        while (lane.tap_val != 8'd30 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_tap30", int'(lane.tap_val), 30);
        rst = 1'b1;
        lane.start = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        lane.start = 1'b0;
        @(posedge clk); #1;
        chk("midrst_start_ignored_state", int'(lane.state_dbg), 0);
        chk("midrst_start_ignored_move",  int'(lane.delay_line_move), 0);
        repeat (2) @(negedge clk);

        // Restart after reset behaves like a fresh training run.
        run_case("restart", 40, 60, 1'b0, 1'b0, 1'b0, mk(1, 0, 40, 60, 50, 61, 11));

        chk("queue_empty", exp_q.size(), 0);
        chk("protocol",    proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_read_training_ctrl.md
LANE_READ_TRAINING_CTRL -- requirements
Module: lane_read_training_ctrl

Interface
REQ-001 Parameter TAP_MAX, default 255, highest legal delay tap (8-bit).
REQ-002 Parameter SETTLE_CYC, default 8, wait cycles after any delay change before sampling.
REQ-003 Parameter SAMPLE_CYC, default 16, compare cycles per tap.
REQ-004 Parameter EXP_PATTERN, default 8'h55, expected RX_DATA word during training.
REQ-005 Parameter MIN_WINDOW, default 4, minimum passing-tap count for success.
REQ-006 FAB_CLK  in  1  sole clock, rising edge.
REQ-007 RX_SYNC_RST  in  1  reset, synchronous, active-high.
REQ-008 START  in  1  single-cycle training request.
REQ-009 RX_DATA  in  8  deserialised lane word from the lane IOD.
REQ-010 EYE_MONITOR_EARLY / EYE_MONITOR_LATE  in  1 each  sticky eye-monitor flags from the IOD.
REQ-011 DELAY_LINE_OUT_OF_RANGE  in  1  IOD delay-line limit flag.
REQ-012 DELAY_LINE_LOAD / DELAY_LINE_MOVE / DELAY_LINE_DIRECTION  out  1 each  IOD delay-line controls; DIRECTION 1 = increment.
REQ-013 EYE_MONITOR_CLEAR_FLAGS  out  1  clears IOD eye-monitor flags.
REQ-014 BUSY / DONE / ERROR  out  1 each  status.
REQ-015 TAP_VAL, WIN_LEFT, WIN_RIGHT  out  8 each  current tap, first passing tap, last passing tap.

Function
REQ-016 FSM states: IDLE, LOAD, SETTLE, CLEAR, SAMPLE, EVAL, STEP, CENTER, DONE, FAIL.
REQ-017 IDLE/DONE/FAIL + START=1 -> LOAD next cycle; clear DONE, ERROR, found_left, WIN_LEFT, WIN_RIGHT; BUSY=1 from LOAD onward.
REQ-018 START ignored in every other state.
REQ-019 LOAD: DELAY_LINE_LOAD=1 for exactly one cycle; TAP_VAL<=0; -> SETTLE.
REQ-020 SETTLE: hold exactly SETTLE_CYC cycles -> CLEAR.
REQ-021 CLEAR: EYE_MONITOR_CLEAR_FLAGS=1 for exactly one cycle; pass flag<=1; -> SAMPLE.
REQ-022 SAMPLE: exactly SAMPLE_CYC cycles; pass flag<=0 on any cycle with RX_DATA!=EXP_PATTERN, EYE_MONITOR_EARLY=1 or EYE_MONITOR_LATE=1; -> EVAL.
REQ-023 EVAL, priority order: (a) pass & !found_left: WIN_LEFT<=TAP_VAL, found_left<=1; (b) !pass & found_left: WIN_RIGHT<=TAP_VAL-1, -> CENTER; (c) TAP_VAL==TAP_MAX or DELAY_LINE_OUT_OF_RANGE=1: if found_left & pass then WIN_RIGHT<=TAP_VAL, -> CENTER, else -> FAIL; (d) otherwise -> STEP. (a) may combine with (c).
REQ-024 STEP: DELAY_LINE_MOVE=1, DIRECTION=1 for one cycle; TAP_VAL<=TAP_VAL+1; -> SETTLE.
REQ-025 CENTER entry: if WIN_RIGHT-WIN_LEFT+1 < MIN_WINDOW -> FAIL; else target=(WIN_LEFT+WIN_RIGHT)>>1 using 9-bit sum, no overflow.
REQ-026 CENTER: while TAP_VAL>target, DELAY_LINE_MOVE=1, DIRECTION=0 one cycle each, TAP_VAL decrements per pulse; TAP_VAL==target -> DONE.
REQ-027 DELAY_LINE_OUT_OF_RANGE=1 during CENTER -> FAIL.
REQ-028 DONE: DONE=1, BUSY=0, held until START or reset; TAP_VAL, WIN_* held.
REQ-029 FAIL: ERROR=1, BUSY=0, held until START or reset.
REQ-030 DELAY_LINE_MOVE and DELAY_LINE_LOAD never asserted in the same cycle; DIRECTION=0 whenever MOVE=0.
REQ-031 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-032 RX_SYNC_RST=1 sampled on a FAB_CLK edge -> IDLE; all outputs 0; counters, found_left and pass flag cleared.
REQ-033 Reset mid-training aborts immediately; no further MOVE/LOAD pulse issued; START in the same cycle as reset ignored.

Verification
REQ-034 Pattern matches taps 40..60 only, START -> one LOAD pulse, 61 increment MOVEs, WIN_LEFT=40, WIN_RIGHT=60, 11 decrement MOVEs, TAP_VAL=50, DONE=1.
REQ-035 Never matches, TAP_MAX=255 -> 255 increment MOVEs, then ERROR=1, DONE=0, BUSY=0.
REQ-036 Passes taps 100..102 only (width 3 < MIN_WINDOW 4) -> ERROR=1, no decrement MOVEs.
REQ-037 Passes from tap 250 through 255 -> WIN_LEFT=250, WIN_RIGHT=255, final TAP_VAL=252, DONE=1.
REQ-038 Eye-monitor EARLY pulse injected at tap 45 inside window 40..60 -> WIN_RIGHT=44, TAP_VAL=42, DONE=1.
REQ-039 RX_SYNC_RST at tap 30 -> next cycle all outputs 0, IDLE; subsequent START restarts from LOAD with TAP_VAL=0.
